// File: rtl/two_digit_counter.sv
// Free-running 00..99 decimal counter with a TICK_DIV prescaler, driving two active-high 7-segment displays.
// Optional build macro LEADING_ZERO_BLANK_EN blanks the tens display while the tens digit is zero.
module two_digit_counter #(
  parameter int TICK_DIV = 1
) (
  input  logic       clock,
  input  logic       reset,
  output logic [6:0] digit1,
  output logic [6:0] digit0
);

  // A width of at least one bit keeps the prescaler legal when TICK_DIV is 1.
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre;
  logic [3:0]       ones;
  logic [3:0]       tens;
  logic             tick;

  // Segment order {a,b,c,d,e,f,g}; non-BCD codes show a dash.
  function automatic logic [6:0] seg7(input logic [3:0] bcd);
    logic [6:0] s;
    case (bcd)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000001;
    endcase
    return s;
  endfunction

  assign tick = (pre == PRE_LAST);

  // Prescaler and BCD digit registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre  <= '0;
      ones <= 4'd0;
      tens <= 4'd0;
    end else if (tick) begin
      pre <= '0;
      if (ones == 4'd9) begin
        ones <= 4'd0;
        tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  // Combinational decode straight from the digit registers
  assign digit0 = seg7(ones);
`ifdef LEADING_ZERO_BLANK_EN
  assign digit1 = (tens == 4'd0) ? 7'b0000000 : seg7(tens);
`else
  assign digit1 = seg7(tens);
`endif

endmodule

// File: tb/tb_two_digit_counter.sv
// Randomized bench for two_digit_counter: a TICK_DIV=1 and a TICK_DIV=4 instance share clock and reset
// and are compared every cycle against a count model derived from edges elapsed since reset release.
module tb_two_digit_counter;

  localparam int DIV_A = 1;
  localparam int DIV_B = 4;

  logic       clock;
  logic       reset;
  logic [6:0] a_digit1, a_digit0;
  logic [6:0] b_digit1, b_digit0;

  int n_checks;
  int n_fail;
  int edges;

  logic [6:0] seg_tab [10];

  two_digit_counter #(.TICK_DIV(DIV_A)) dut_a (
    .clock (clock),
    .reset (reset),
    .digit1(a_digit1),
    .digit0(a_digit0)
  );

  two_digit_counter #(.TICK_DIV(DIV_B)) dut_b (
    .clock (clock),
    .reset (reset),
    .digit1(b_digit1),
    .digit0(b_digit0)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [6:0] observed, input logic [6:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed %b expected %b at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [6:0] tens_seg(input int value);
    int t;
    t = value / 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (t == 0) return 7'b0000000;
`endif
    return seg_tab[t];
  endfunction

  // Displayed value is simply completed prescale periods since release, modulo 100.
  task automatic check_all(input string tag);
    int va, vb;
    va = (edges / DIV_A) % 100;
    vb = (edges / DIV_B) % 100;
    check({tag, " a.digit1"}, a_digit1, tens_seg(va));
    check({tag, " a.digit0"}, a_digit0, seg_tab[va % 10]);
    check({tag, " b.digit1"}, b_digit1, tens_seg(vb));
    check({tag, " b.digit0"}, b_digit0, seg_tab[vb % 10]);
  endtask

  task automatic run_edges(input int k, input string tag);
    for (int i = 0; i < k; i++) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
      check_all(tag);
    end
  endtask

  // Assert reset between clock edges and confirm the display clears before the next edge.
  task automatic async_reset(input int offset, input string tag);
    @(negedge clock);
    #(offset);
    reset = 1'b1;
    edges = 0;
    #1;
    check_all(tag);
    @(negedge clock);
    check_all({tag, " held"});
    reset = 1'b0;
  endtask

  initial begin
    seg_tab[0] = 7'b1111110; seg_tab[1] = 7'b0110000; seg_tab[2] = 7'b1101101;
    seg_tab[3] = 7'b1111001; seg_tab[4] = 7'b0110011; seg_tab[5] = 7'b1011011;
    seg_tab[6] = 7'b1011111; seg_tab[7] = 7'b1110000; seg_tab[8] = 7'b1111111;
    seg_tab[9] = 7'b1111011;
    n_checks = 0;
    n_fail   = 0;
    edges    = 0;

    // Reset held for 500 ns: display stays at 00 across every edge.
    reset = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      check_all("reset hold");
    end
    reset = 1'b0;

    // 150 edges: covers 01, 09, the 10 carry, 99 and the wrap to 00 on the fast
    // instance, and leaves the TICK_DIV=4 instance at 37.
    run_edges(150, "count");
    async_reset(3, "reset at 37");

    for (int r = 0; r < 8; r++) begin
      run_edges(int'($urandom_range(1, 260)), "random run");
      async_reset(int'($urandom_range(1, 8)), "random reset");
    end
    run_edges(12, "final run");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
